// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS front end.
package mips_pkg;

   typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} fetch_state_t;

   localparam logic [31:0] INSN_NOP         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic is_word_aligned(input logic [1:0] i_lsb);
      return i_lsb == 2'b00;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register: async active-low reset to RESET_PC, load enable.
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [31:0] i_d,
   output logic [31:0] o_q
);

   logic [31:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_q <= RESET_PC;
      else if (i_load) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: holds PC, runs the req/gnt/rvalid handshake and presents i_fetch/pc to decode.
// Optional HALT_ON_ZERO_EN: an all-zero fetched word halts fetch instead of being forwarded.
module pc_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] i_fetch,
   output logic        fetch_valid,
   output logic        halted
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  w_pc;
   logic [31:0]  r_ifetch;
   logic         r_fetch_valid, r_halted;
   logic         w_pc_load, w_latch, w_fv_set, w_fv_clr, w_halt_set;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_pc_load),
      .i_d    (next_pc),
      .o_q    (w_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= REQ;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_load   = 1'b0;
      w_latch     = 1'b0;
      w_fv_set    = 1'b0;
      w_fv_clr    = 1'b0;
      w_halt_set  = 1'b0;
      case (r_state)
         REQ:  if (imem_gnt) w_state_nxt = WAIT;
         WAIT: if (imem_rvalid) begin
            w_latch = 1'b1;
`ifdef HALT_ON_ZERO_EN
            if (imem_rdata == INSN_NOP) begin
               w_halt_set  = 1'b1;
               w_state_nxt = HALT;
            end else begin
               w_fv_set    = 1'b1;
               w_state_nxt = HOLD;
            end
`else
            w_fv_set    = 1'b1;
            w_state_nxt = HOLD;
`endif
         end
         HOLD: if (!stall) begin
            // Misaligned target still lands in pc so the faulting address is visible.
            w_fv_clr  = 1'b1;
            w_pc_load = 1'b1;
            if (!is_word_aligned(next_pc[1:0])) begin
               w_halt_set  = 1'b1;
               w_state_nxt = HALT;
            end else begin
               w_state_nxt = REQ;
            end
         end
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifetch      <= 32'h0;
         r_fetch_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         if (w_latch)    r_ifetch      <= imem_rdata;
         if (w_fv_set)   r_fetch_valid <= 1'b1;
         if (w_fv_clr)   r_fetch_valid <= 1'b0;
         if (w_halt_set) r_halted      <= 1'b1;
      end
   end

   // State resets to REQ, but no request may be presented while reset is held.
   assign imem_req    = (r_state == REQ) && rst_n;
   assign imem_addr   = w_pc;
   assign pc          = w_pc;
   assign i_fetch     = r_ifetch;
   assign fetch_valid = r_fetch_valid;
   assign halted      = r_halted;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed table-driven bench for pc_fetch_stage plus hand sequences for reset and zero-word cases.
module tb_pc_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] i_fetch;
   logic        fetch_valid;
   logic        halted;

   int n_checks = 0;
   int n_err    = 0;

   pc_fetch_stage #(.RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .next_pc     (next_pc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .i_fetch     (i_fetch),
      .fetch_valid (fetch_valid),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] npc;
      logic        stl;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] epc;
      logic        fv;
      logic [31:0] ins;
      logic        hlt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] npc, input logic stl, input logic gnt, input logic rv,
                      input logic [31:0] rdata, input logic req, input logic [31:0] epc,
                      input logic fv, input logic [31:0] ins, input logic hlt);
      vec_t v;
      v.npc = npc; v.stl = stl; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.req = req; v.epc = epc; v.fv = fv; v.ins = ins; v.hlt = hlt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] npc, input logic stl, input logic gnt, input logic rv,
                        input logic [31:0] rdata);
      next_pc = npc; stall = stl; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [31:0] epc,
                             input logic fv, input logic [31:0] ins, input logic hlt);
      chk({tag, ".imem_req"},    {31'b0, imem_req},    {31'b0, req});
      chk({tag, ".imem_addr"},   imem_addr,            epc);
      chk({tag, ".pc"},          pc,                   epc);
      chk({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, fv});
      chk({tag, ".halted"},      {31'b0, halted},      {31'b0, hlt});
      if (fv) chk({tag, ".i_fetch"}, i_fetch, ins);
   endtask

   initial begin
      // Fetch/stall/delayed-handshake/misaligned-halt sequence, one row per cycle.
      //   next_pc       stl gnt rv rdata          req pc            fv ins            hlt
      add(32'h4,        0,  1,  0, 32'h0,         1,  32'h0,        0, 32'h0,         0);
      add(32'h4,        0,  0,  1, 32'h2008_0005, 0,  32'h0,        0, 32'h0,         0);
      add(32'h4,        1,  0,  0, 32'h0,         0,  32'h0,        1, 32'h2008_0005, 0);
      add(32'h4,        1,  1,  1, 32'h0,         0,  32'h0,        1, 32'h2008_0005, 0);
      add(32'h4,        1,  0,  0, 32'h0,         0,  32'h0,        1, 32'h2008_0005, 0);
      add(32'h4,        1,  0,  1, 32'hFFFF_FFFF, 0,  32'h0,        1, 32'h2008_0005, 0);
      add(32'h40,       0,  0,  0, 32'h0,         0,  32'h0,        1, 32'h2008_0005, 0);
      add(32'h4,        0,  1,  0, 32'h0,         1,  32'h40,       0, 32'h0,         0);
      add(32'h4,        0,  0,  1, 32'h1111_0000, 0,  32'h40,       0, 32'h0,         0);
      add(32'h8,        0,  0,  0, 32'h0,         0,  32'h40,       1, 32'h1111_0000, 0);
      add(32'h4,        0,  0,  1, 32'hDEAD_BEEF, 1,  32'h8,        0, 32'h0,         0);
      add(32'h4,        0,  0,  0, 32'h0,         1,  32'h8,        0, 32'h0,         0);
      add(32'h4,        0,  0,  0, 32'h0,         1,  32'h8,        0, 32'h0,         0);
      add(32'h4,        0,  1,  0, 32'h0,         1,  32'h8,        0, 32'h0,         0);
      add(32'h4,        0,  0,  0, 32'h0,         0,  32'h8,        0, 32'h0,         0);
      add(32'h4,        0,  1,  0, 32'h0,         0,  32'h8,        0, 32'h0,         0);
      add(32'h4,        0,  0,  1, 32'h2222_3333, 0,  32'h8,        0, 32'h0,         0);
      add(32'h42,       0,  0,  0, 32'h0,         0,  32'h8,        1, 32'h2222_3333, 0);
      add(32'h4,        0,  1,  1, 32'h0,         0,  32'h42,       0, 32'h0,         1);
      add(32'h80,       0,  1,  1, 32'h1234_5678, 0,  32'h42,       0, 32'h0,         1);
      add(32'h4,        1,  1,  0, 32'h0,         0,  32'h42,       0, 32'h0,         1);
      add(32'h4,        0,  0,  1, 32'h0,         0,  32'h42,       0, 32'h0,         1);

      rst_n = 1'b0;
      drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("reset.i_fetch", i_fetch, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].npc, vecs[i].stl, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
         #1;
         expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].epc, vecs[i].fv,
                    vecs[i].ins, vecs[i].hlt);
      end

      // Reset out of HALT, start a fetch, then reset again while waiting for rvalid.
      @(negedge clk); rst_n = 1'b0; drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0); #1;
      expect_out("rst_from_halt", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); drive(32'h4, 1'b0, 1'b1, 1'b0, 32'h0); #1;
      expect_out("r5_req", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0); #1;
      expect_out("r5_wait", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); rst_n = 1'b0; #1;
      expect_out("r5_rst_in_wait", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); rst_n = 1'b1; drive(32'h4, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF); #1;
      expect_out("r5_stray_rvalid", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); drive(32'h4, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF); #1;
      expect_out("r5_gnt_rvalid", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); drive(32'h4, 1'b0, 1'b0, 1'b1, 32'h2008_0005); #1;
      expect_out("r5_wait2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk); drive(32'h8, 1'b0, 1'b0, 1'b0, 32'h0); #1;
      expect_out("r5_hold", 1'b0, 32'h0, 1'b1, 32'h2008_0005, 1'b0);

      // Zero word fetched from address 8.
      @(negedge clk); drive(32'h4, 1'b0, 1'b1, 1'b0, 32'h0); #1;
      expect_out("z_req", 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
      @(negedge clk); drive(32'h4, 1'b0, 1'b0, 1'b1, 32'h0); #1;
      expect_out("z_wait", 1'b0, 32'h8, 1'b0, 32'h0, 1'b0);
`ifdef HALT_ON_ZERO_EN
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(32'hC, 1'b0, 1'b1, 1'b1, 32'h5); #1;
         expect_out($sformatf("z_halt%0d", k), 1'b0, 32'h8, 1'b0, 32'h0, 1'b1);
      end
`else
      @(negedge clk); drive(32'hC, 1'b0, 1'b0, 1'b0, 32'h0); #1;
      expect_out("z_nop_hold", 1'b0, 32'h8, 1'b1, 32'h0, 1'b0);
      @(negedge clk); drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0); #1;
      expect_out("z_nop_next", 1'b1, 32'hC, 1'b0, 32'h0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
